// File: rtl/si5340_cfg_pkg.sv
// Shared types and constants for the Si5340 configuration sequencer.
// The byte-command struct mirrors what the downstream I2C byte engine consumes.
package si5340_cfg_pkg;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        WAIT_ROM,
        PAGE_CHECK,
        SEND,
        WAIT_RSP,
        NEXT,
        DELAY,
        DONE,
        ERROR
    } cfg_state_t;

    localparam logic [7:0] SI5340_PAGE_REG     = 8'h01;
    localparam logic [6:0] SI5340_DEFAULT_ADDR = 7'h74;
    localparam logic [7:0] PAGE_INVALID        = 8'hFF;

    typedef struct packed {
        logic       start;
        logic       stop;
        logic [7:0] data;
    } byte_cmd_t;

    // Every transaction is three bytes: START on the first, STOP on the last.
    function automatic byte_cmd_t make_cmd(input logic [1:0] byte_idx, input logic [7:0] data);
        byte_cmd_t cmd;
        cmd.start = (byte_idx == 2'd0);
        cmd.stop  = (byte_idx == 2'd2);
        cmd.data  = data;
        return cmd;
    endfunction

endpackage

// File: rtl/si5340_cfg_sequencer_if.sv
// Byte-command / response channel between the config sequencer and the I2C byte engine.
interface si5340_cfg_sequencer_if;
    import si5340_cfg_pkg::*;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_data;
    logic       cmd_start;
    logic       cmd_stop;
    logic       rsp_valid;
    logic       rsp_nack;

    modport master (
        output cmd_valid, cmd_data, cmd_start, cmd_stop,
        input  cmd_ready, rsp_valid, rsp_nack
    );

    modport slave (
        input  cmd_valid, cmd_data, cmd_start, cmd_stop,
        output cmd_ready, rsp_valid, rsp_nack
    );

endinterface

// File: rtl/si5340_cfg_sequencer_delay_timer.sv
// Loadable down-counter used for the post-preamble settling delay.
// expired is high whenever the count has reached zero.
module cfg_delay_timer
    import si5340_cfg_pkg::*;
#(
    parameter int WIDTH = 26
) (
    input  logic             clk_i,
    input  logic             arstn_i,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/si5340_cfg_sequencer.sv
// Walks the Si5340 config ROM and turns each word into framed I2C write transactions,
// inserting page writes, NACK retries and the post-preamble settling delay.
module si5340_cfg_sequencer
    import si5340_cfg_pkg::*;
#(
    parameter int         MEM_WIDTH      = 24,
    parameter int         WORD_NUMBER    = 326,
    parameter logic [6:0] SLAVE_ADDR     = SI5340_DEFAULT_ADDR,
    parameter int         PREAMBLE_WORDS = 3,
    parameter int         DELAY_CYCLES   = 37_500_000,
    parameter int         MAX_RETRY      = 3,
    localparam int        AW             = (WORD_NUMBER > 1) ? $clog2(WORD_NUMBER) : 1
) (
    input  logic                 clk_i,
    input  logic                 arstn_i,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o,
    output logic [AW-1:0]        rd_addr_o,
    input  logic [MEM_WIDTH-1:0] rd_data_i,
    si5340_cfg_sequencer_if.master i2c
);

    localparam int            DW          = (DELAY_CYCLES > 0) ? $clog2(DELAY_CYCLES + 1) : 1;
    localparam int            RW          = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [AW-1:0] LAST_IDX    = AW'(WORD_NUMBER - 1);
    localparam logic [AW-1:0] PRE_IDX     = AW'((PREAMBLE_WORDS > 0) ? PREAMBLE_WORDS - 1 : 0);
    localparam logic          USE_DELAY   = (PREAMBLE_WORDS != 0) && (DELAY_CYCLES != 0);
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);
    localparam logic [DW-1:0] DELAY_LOAD  = DW'(DELAY_CYCLES);

    cfg_state_t    state, state_next;
    logic [AW-1:0] index, index_next;
    logic [7:0]    cur_page, cur_page_next;
    logic [23:0]   word, word_next;
    logic [1:0]    byte_idx, byte_next;
    logic          is_page, is_page_next;
    logic [RW-1:0] retry, retry_next;
    logic          done_r, done_next;
    logic          error_r, error_next;
    logic          timer_load;
    logic          timer_expired;
    logic          advance;
    logic [7:0]    byte_data;
    byte_cmd_t     cmd;

    cfg_delay_timer #(
        .WIDTH (DW)
    ) u_delay_timer (
        .clk_i      (clk_i),
        .arstn_i    (arstn_i),
        .load       (timer_load),
        .load_value (DELAY_LOAD),
        .expired    (timer_expired)
    );

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state    <= IDLE;
            index    <= '0;
            cur_page <= PAGE_INVALID;
            word     <= '0;
            byte_idx <= '0;
            is_page  <= 1'b0;
            retry    <= '0;
            done_r   <= 1'b0;
            error_r  <= 1'b0;
        end else begin
            state    <= state_next;
            index    <= index_next;
            cur_page <= cur_page_next;
            word     <= word_next;
            byte_idx <= byte_next;
            is_page  <= is_page_next;
            retry    <= retry_next;
            done_r   <= done_next;
            error_r  <= error_next;
        end
    end

    // DONE and ERROR are pass-through: the flag is latched and the FSM lands in IDLE
    // on the same edge, so busy_o drops together with the flag rising.
    always_comb begin
        state_next    = state;
        index_next    = index;
        cur_page_next = cur_page;
        word_next     = word;
        byte_next     = byte_idx;
        is_page_next  = is_page;
        retry_next    = retry;
        done_next     = done_r;
        error_next    = error_r;
        timer_load    = 1'b0;
        advance       = 1'b0;

        case (state)
            IDLE: begin
                if (start_i) begin
                    state_next    = FETCH;
                    index_next    = '0;
                    cur_page_next = PAGE_INVALID;
                    done_next     = 1'b0;
                    error_next    = 1'b0;
                end
            end
            FETCH:    state_next = WAIT_ROM;
            WAIT_ROM: state_next = PAGE_CHECK;
            PAGE_CHECK: begin
                word_next    = rd_data_i[23:0];
                is_page_next = (rd_data_i[23:16] != cur_page);
                byte_next    = 2'd0;
                retry_next   = '0;
                state_next   = SEND;
            end
            SEND: begin
                if (i2c.cmd_ready) begin
                    state_next = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (i2c.rsp_valid) begin
                    if (i2c.rsp_nack) begin
                        if (retry < RETRY_LIMIT) begin
                            retry_next = retry + 1'b1;
                            byte_next  = 2'd0;
                            state_next = SEND;
                        end else begin
                            state_next = ERROR;
                        end
                    end else if (byte_idx != 2'd2) begin
                        byte_next  = byte_idx + 2'd1;
                        state_next = SEND;
                    end else if (is_page) begin
                        // Page is only trusted once the device has acknowledged it.
                        cur_page_next = word[23:16];
                        is_page_next  = 1'b0;
                        byte_next     = 2'd0;
                        retry_next    = '0;
                        state_next    = SEND;
                    end else begin
                        state_next = NEXT;
                    end
                end
            end
            NEXT: begin
                if (USE_DELAY && (index == PRE_IDX)) begin
                    timer_load = 1'b1;
                    state_next = DELAY;
                end else begin
                    advance = 1'b1;
                end
            end
            DELAY: begin
                if (timer_expired) begin
                    advance = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (advance) begin
            if (index == LAST_IDX) begin
                state_next = DONE;
            end else begin
                index_next = index + 1'b1;
                state_next = FETCH;
            end
        end

        if (state_next == DONE) begin
            done_next  = 1'b1;
            state_next = IDLE;
        end
        if (state_next == ERROR) begin
            error_next = 1'b1;
            state_next = IDLE;
        end
    end

    always_comb begin
        byte_data = {SLAVE_ADDR, 1'b0};
        cmd       = '0;
        case (byte_idx)
            2'd1:    byte_data = is_page ? SI5340_PAGE_REG : word[15:8];
            2'd2:    byte_data = is_page ? word[23:16] : word[7:0];
            default: byte_data = {SLAVE_ADDR, 1'b0};
        endcase
        if (state == SEND) begin
            cmd = make_cmd(byte_idx, byte_data);
        end
    end

    assign busy_o        = (state != IDLE);
    assign done_o        = done_r;
    assign error_o       = error_r;
    assign rd_addr_o     = index;
    assign i2c.cmd_valid = (state == SEND);
    assign i2c.cmd_data  = cmd.data;
    assign i2c.cmd_start = cmd.start;
    assign i2c.cmd_stop  = cmd.stop;

endmodule

// File: tb/tb_si5340_cfg_sequencer.sv
// Randomized bench: a behavioural byte engine with backpressure, NACK injection and stray
// responses, compared against a transaction-level model of the expected byte stream.
module tb_si5340_cfg_sequencer;

    localparam int NW        = 4;
    localparam int PRE       = 1;
    localparam int DLY       = 20;
    localparam int RETRIES   = 1;
    localparam int NACK_SLOTS = 64;

    logic        clk;
    logic        arstn;
    logic        start;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  rd_addr;
    logic [23:0] rd_data;

    si5340_cfg_sequencer_if bus ();

    si5340_cfg_sequencer #(
        .MEM_WIDTH      (24),
        .WORD_NUMBER    (NW),
        .SLAVE_ADDR     (7'h74),
        .PREAMBLE_WORDS (PRE),
        .DELAY_CYCLES   (DLY),
        .MAX_RETRY      (RETRIES)
    ) dut (
        .clk_i     (clk),
        .arstn_i   (arstn),
        .start_i   (start),
        .busy_o    (busy),
        .done_o    (done),
        .error_o   (error),
        .rd_addr_o (rd_addr),
        .rd_data_i (rd_data),
        .i2c       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [23:0] rom [NW];
    always @(posedge clk) rd_data <= rom[rd_addr];

    int   checks = 0;
    int   errors = 0;
    int   run_id = 0;
    logic force_stall = 1'b0;
    logic nack_at [NACK_SLOTS];

    logic [9:0] exp_q [$];
    logic       exp_err;
    int         delay_start;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Byte engine model, driven on the falling edge.
    int         cyc = 0;
    int         last_rsp = 0;
    int         phase = 0;
    int         lat = 0;
    int         stall = 0;
    int         acc_cnt = 0;
    int         hold_bad = 0;
    int         overlap_bad = 0;
    int         seen_run = 0;
    logic       seen = 1'b0;
    logic       pend_nack = 1'b0;
    logic [9:0] snap;
    logic [9:0] cur_cmd;
    logic [9:0] got_q [$];
    int         gap_q [$];

    assign cur_cmd = {bus.cmd_start, bus.cmd_stop, bus.cmd_data};

    initial begin
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_nack  = 1'b0;
    end

    always @(negedge clk) begin
        cyc++;
        bus.rsp_valid = 1'b0;
        bus.rsp_nack  = 1'b0;
        if (!arstn || seen_run != run_id) begin
            seen_run      = run_id;
            phase         = 0;
            seen          = 1'b0;
            acc_cnt       = 0;
            hold_bad      = 0;
            overlap_bad   = 0;
            last_rsp      = cyc;
            bus.cmd_ready = 1'b0;
            got_q.delete();
            gap_q.delete();
        end else begin
            case (phase)
                0: begin
                    if (bus.cmd_valid) begin
                        if (!seen) begin
                            seen = 1'b1;
                            snap = cur_cmd;
                            gap_q.push_back(cyc - last_rsp);
                            stall = (force_stall || $urandom_range(0, 2) == 0) ? 5 : 0;
                        end else if (cur_cmd !== snap) begin
                            hold_bad++;
                        end
                        if (stall > 0) begin
                            stall--;
                            bus.cmd_ready = 1'b0;
                        end else begin
                            bus.cmd_ready = 1'b1;
                            got_q.push_back(cur_cmd);
                            pend_nack = (acc_cnt < NACK_SLOTS) ? nack_at[acc_cnt] : 1'b0;
                            acc_cnt++;
                            seen  = 1'b0;
                            phase = 1;
                        end
                    end else if ($urandom_range(0, 7) == 0) begin
                        bus.rsp_valid = 1'b1;
                        bus.rsp_nack  = 1'($urandom_range(0, 1));
                    end
                end
                1: begin
                    bus.cmd_ready = 1'b0;
                    if (bus.cmd_valid) overlap_bad++;
                    lat   = $urandom_range(0, 2);
                    phase = 2;
                end
                default: begin
                    if (bus.cmd_valid) overlap_bad++;
                    if (lat == 0) begin
                        bus.rsp_valid = 1'b1;
                        bus.rsp_nack  = pend_nack;
                        last_rsp      = cyc;
                        phase         = 0;
                    end else begin
                        lat--;
                    end
                end
            endcase
        end
    end

    // Expected byte stream from the ROM contents and the NACK plan, transaction by transaction.
    task automatic build_model();
        int         cnt = 0;
        int         page = 255;
        int         starts = 0;
        int         tries;
        logic       ok;
        logic [7:0] bytes [3];
        exp_q.delete();
        exp_err     = 1'b0;
        delay_start = -1;
        for (int w = 0; w < NW; w++) begin
            if (w == PRE) delay_start = starts;
            for (int ph = 0; ph < 2; ph++) begin
                if (ph == 0 && int'(rom[w][23:16]) == page) continue;
                bytes[0] = 8'hE8;
                bytes[1] = (ph == 0) ? 8'h01 : rom[w][15:8];
                bytes[2] = (ph == 0) ? rom[w][23:16] : rom[w][7:0];
                tries = 0;
                ok    = 1'b0;
                while (!ok) begin
                    ok = 1'b1;
                    for (int b = 0; b < 3; b++) begin
                        exp_q.push_back({b == 0, b == 2, bytes[b]});
                        if (b == 0) starts++;
                        if (cnt < NACK_SLOTS && nack_at[cnt]) ok = 1'b0;
                        cnt++;
                        if (!ok) break;
                    end
                    if (!ok) begin
                        tries++;
                        if (tries > RETRIES) begin
                            exp_err     = 1'b1;
                            delay_start = -1;
                            return;
                        end
                    end
                end
                if (ph == 0) page = int'(rom[w][23:16]);
            end
        end
    endtask

    task automatic applyStimulus(input string tag);
        int waited;
        int bad_gaps;
        int start_seen;
        build_model();
        run_id++;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput({tag, "_busy_n1"}, 32'(busy), 32'd1);
        checkOutput({tag, "_rdaddr_n1"}, 32'(rd_addr), 32'd0);
        checkOutput({tag, "_flags_cleared"}, 32'({done, error}), 32'd0);
        @(negedge clk);
        checkOutput({tag, "_no_cmd_n2"}, 32'(bus.cmd_valid), 32'd0);
        @(negedge clk);
        checkOutput({tag, "_no_cmd_n3"}, 32'(bus.cmd_valid), 32'd0);
        @(negedge clk);
        checkOutput({tag, "_first_cmd_n4"}, 32'(bus.cmd_valid), 32'd1);
        repeat (30) @(negedge clk);
        if (busy) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        waited = 0;
        while (busy && waited < 4000) begin
            @(negedge clk);
            waited++;
        end
        checkOutput({tag, "_terminates"}, 32'(busy), 32'd0);
        repeat (10) @(negedge clk);
        checkOutput({tag, "_done"}, 32'(done), 32'(!exp_err));
        checkOutput({tag, "_error"}, 32'(error), 32'(exp_err));
        checkOutput({tag, "_byte_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checkOutput($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        end
        checkOutput({tag, "_hold_stable"}, 32'(hold_bad), 32'd0);
        checkOutput({tag, "_single_outstanding"}, 32'(overlap_bad), 32'd0);
        bad_gaps = 0;
        for (int i = 0; i < got_q.size() && i < gap_q.size(); i++) begin
            if (!got_q[i][9] && gap_q[i] != 1) bad_gaps++;
        end
        checkOutput({tag, "_byte_gap"}, 32'(bad_gaps), 32'd0);
        if (delay_start >= 0) begin
            start_seen = 0;
            waited     = -1;
            for (int i = 0; i < got_q.size() && i < gap_q.size(); i++) begin
                if (got_q[i][9]) begin
                    if (start_seen == delay_start) waited = gap_q[i];
                    start_seen++;
                end
            end
            checkOutput({tag, "_settle_delay"}, 32'(waited >= DLY), 32'd1);
        end
    endtask

    task automatic reset_mid_transaction();
        int waited;
        for (int i = 0; i < NACK_SLOTS; i++) nack_at[i] = 1'b0;
        run_id++;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (!(bus.cmd_valid && !bus.cmd_start && !bus.cmd_stop) && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("reset_mid_reached_byte1", 32'(waited < 500), 32'd1);
        #2 arstn = 1'b0;
        #1;
        checkOutput("reset_mid_outputs",
                    32'({busy, done, error, bus.cmd_valid, bus.cmd_start, bus.cmd_stop, bus.cmd_data, rd_addr}),
                    32'd0);
        @(negedge clk);
        @(negedge clk);
        arstn = 1'b1;
    endtask

    initial begin
        #800_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        arstn = 1'b0;
        start = 1'b0;
        for (int i = 0; i < NACK_SLOTS; i++) nack_at[i] = 1'b0;
        rom[0] = 24'h000B24;
        rom[1] = 24'h000C11;
        rom[2] = 24'h021A05;
        rom[3] = 24'h021B06;
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs",
                    32'({busy, done, error, bus.cmd_valid, bus.cmd_start, bus.cmd_stop, bus.cmd_data, rd_addr}),
                    32'd0);
        arstn = 1'b1;
        @(negedge clk);

        $display("[TB] directed: page change and same page, forced backpressure");
        force_stall = 1'b1;
        applyStimulus("plan");
        force_stall = 1'b0;

        $display("[TB] directed: single NACK recovered by retry");
        nack_at[0] = 1'b1;
        applyStimulus("nack_once");

        $display("[TB] directed: NACK twice exhausts retries");
        nack_at[1] = 1'b1;
        applyStimulus("nack_twice");

        $display("[TB] directed: reset in the middle of a transaction");
        reset_mid_transaction();
        applyStimulus("after_reset");

        for (int r = 0; r < 12; r++) begin
            for (int w = 0; w < NW; w++) begin
                rom[w] = {8'($urandom_range(0, 2)), 8'($urandom), 8'($urandom)};
            end
            for (int i = 0; i < NACK_SLOTS; i++) nack_at[i] = ($urandom_range(0, 11) == 0);
            applyStimulus($sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
